// File: rtl/riscv_pkg.sv
// Shared constants and types for the 3-stage RISC-V pipeline.
// Used by fetch, the controller and the memory map.
//   NOP          : bubble word (addi x0,x0,0)
//   RESET_PC     : first fetch address after reset release (BIOS base)
//   *_REGION     : pc[31:28] nibble selecting each memory
//   *_AW         : word-address widths of BIOS and IMEM
package riscv_pkg;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC    = 32'h4000_0000;

  localparam logic [3:0]  BIOS_REGION = 4'h4;
  localparam logic [3:0]  IMEM_REGION = 4'h1;

  localparam int unsigned BIOS_AW     = 12;
  localparam int unsigned IMEM_AW     = 14;

  // Encoding is {is_imem, is_bios} so the two regions are one-hot.
  typedef enum logic [1:0] {
    SrcNone = 2'b00,
    SrcBios = 2'b01,
    SrcImem = 2'b10
  } fetch_src_e;

  function automatic fetch_src_e region_decode(input logic [31:0] addr);
    fetch_src_e src;
    src = SrcNone;
    if (addr[31:28] == BIOS_REGION) begin
      src = SrcBios;
    end else if (addr[31:28] == IMEM_REGION) begin
      src = SrcImem;
    end
    return src;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection and region decode for the fetch stage.
// Priority: redirect > stall > sequential (pc + 4, wraps silently).
// Ports:
//   pc_cur          : address fetched last cycle
//   stall           : hold the current address
//   redirect        : EX takes a branch/jump
//   redirect_target : EX-stage target (low two bits ignored)
//   next_pc         : address to issue this cycle
//   next_src        : memory that will return the word for next_pc
module fetch_next_pc
  import riscv_pkg::*;
(
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output fetch_src_e  next_src
);

  always_comb begin
    next_pc = pc_cur + 32'd4;
    if (redirect) begin
      next_pc = {redirect_target[31:2], 2'b00};
    end else if (stall) begin
      next_pc = pc_cur;
    end
    next_src = region_decode(next_pc);
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 3-stage RISC-V pipeline. Owns the PC, issues synchronous-read
// word addresses to BIOS and IMEM, selects the returned word for decode, and
// squashes wrong-path slots on redirect. Counts delivered instructions.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   stall           : hold fetch; decode keeps the same instruction
//   redirect        : PCSel from the controller
//   redirect_target : ALU result (EX-stage target)
//   bios_addr/dout  : BIOS port A, data valid one cycle after address
//   imem_addr/dout  : IMEM, data valid one cycle after address
//   inst, pc        : instruction to decode and its PC
//   inst_count      : real instructions delivered
//   count_clr       : synchronous clear of inst_count
module fetch_stage #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP      = riscv_pkg::NOP
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_target,
  output logic [riscv_pkg::BIOS_AW-1:0] bios_addr,
  input  logic [31:0]                  bios_dout,
  output logic [riscv_pkg::IMEM_AW-1:0] imem_addr,
  input  logic [31:0]                  imem_dout,
  output logic [31:0]                  inst,
  output logic [31:0]                  pc,
  output logic [31:0]                  inst_count,
  input  logic                         count_clr
);

  logic [31:0]           pc_q;
  logic                  valid_q;
  riscv_pkg::fetch_src_e src_q;
  logic [31:0]           count_q;

  logic [31:0]           next_pc;
  riscv_pkg::fetch_src_e next_src;
  logic                  deliver;

  fetch_next_pc u_next_pc (
    .pc_cur          (pc_q),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .next_pc         (next_pc),
    .next_src        (next_src)
  );

  // Both memories see the address every cycle; src_q picks the answer later.
  assign bios_addr = next_pc[riscv_pkg::BIOS_AW+1:2];
  assign imem_addr = next_pc[riscv_pkg::IMEM_AW+1:2];

  // pc_q resets one word below RESET_PC so the sequential path issues RESET_PC
  // first and the reset cycle presents no instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC - 32'd4;
      valid_q <= 1'b0;
      src_q   <= riscv_pkg::SrcNone;
    end else begin
      pc_q    <= next_pc;
      valid_q <= 1'b1;
      src_q   <= next_src;
    end
  end

  // The slot in decode during a redirect is wrong-path: replaced by NOP.
  always_comb begin
    inst = NOP;
    if (valid_q && !redirect) begin
      case (src_q)
        riscv_pkg::SrcBios: inst = bios_dout;
        riscv_pkg::SrcImem: inst = imem_dout;
        default:            inst = NOP;
      endcase
    end
  end

  assign pc = pc_q;

  // A slot counts only when it really leaves decode: not stalled, not squashed.
  assign deliver = valid_q && !redirect && !stall && (src_q != riscv_pkg::SrcNone);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 32'd0;
    end else if (count_clr) begin
      count_q <= 32'd0;
    end else if (deliver) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign inst_count = count_q;

endmodule
